// File: rtl/machina_pkg.sv
// Shared helpers for the serialize/deserialize lane pair.
// Defines the beat tag layout once so both ends agree.
package machina_pkg;

  // Index tag width for a vector of n words
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Beat width: index tag on top of the value
  function automatic int beat_w(input int n, input int w);
    return idx_w(n) + w;
  endfunction

  // Number of set bits in a received-flags mask (up to 32 words)
  function automatic int popcount(input logic [31:0] m);
    int c;
    c = 0;
    for (int i = 0; i < 32; i++) begin
      c += int'(m[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/deserialize.sv
// Reassembles index-tagged scalar beats into one parallel vector.
// Collection buffer plus output register allow back-to-back vectors.
module deserialize
  import machina_pkg::*;
#(
  parameter  int RESW = 16,
  parameter  int RESN = 4,
  localparam int IDXW = idx_w(RESN),
  localparam int ARGW = beat_w(RESN, RESW)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 arg_valid,
  input  logic [ARGW-1:0]      arg_data,
  output logic                 arg_ready,
  output logic                 res_valid,
  output logic [RESN*RESW-1:0] res_data,
  input  logic                 res_ready,
  output logic                 err
);

  localparam logic [IDXW:0] NMAX = (IDXW+1)'(RESN);

  logic [RESN-1:0]           mask_q, mask_d;
  logic [RESN-1:0][RESW-1:0] buf_q, buf_d;
  logic [RESN-1:0][RESW-1:0] out_q, out_d;
  logic                      res_valid_q, res_valid_d;
  logic                      err_q, err_d;

  logic [IDXW-1:0] idx;
  logic [RESW-1:0] val;
  logic            in_range;
  logic            dup;
  logic            acc;
  logic            complete;
  logic [RESN-1:0] mask_new;

  assign idx = arg_data[ARGW-1 -: IDXW];
  assign val = arg_data[RESW-1:0];

  // Room for a beat unless it could complete a vector that has nowhere to go
  always_comb begin
    arg_ready = !res_valid_q || res_ready
             || (popcount(32'(mask_q)) < RESN - 1);
  end

  // Beat classification and next-state for buffer, mask, output and error
  always_comb begin
    in_range    = ({1'b0, idx} < NMAX);
    acc         = arg_valid && arg_ready;
    dup         = 1'b0;
    mask_new    = mask_q;
    complete    = 1'b0;
    buf_d       = buf_q;
    out_d       = out_q;
    mask_d      = mask_q;
    err_d       = err_q;
    res_valid_d = res_valid_q;

    if (in_range) begin
      dup = mask_q[idx];
      mask_new[idx] = 1'b1;
    end

    if (acc && in_range) begin
      buf_d[idx] = val;
      mask_d     = mask_new;
      complete   = !dup && (&mask_new);
    end

    if (acc && (!in_range || dup)) begin
      err_d = 1'b1;
    end

    // A consume frees the register; a completion on the same edge refills it
    if (res_valid_q && res_ready) begin
      res_valid_d = 1'b0;
    end

    if (complete) begin
      out_d       = buf_d;
      mask_d      = '0;
      res_valid_d = 1'b1;
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_q      <= '0;
      buf_q       <= '0;
      out_q       <= '0;
      res_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      mask_q      <= mask_d;
      buf_q       <= buf_d;
      out_q       <= out_d;
      res_valid_q <= res_valid_d;
      err_q       <= err_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = out_q;
  assign err       = err_q;

endmodule

// File: tb/tb_deserialize.sv
// Directed self-checking bench for deserialize.
// Hand-computed vectors with immediate assertions.
module tb_deserialize;

  logic        clk;
  logic        rst;
  logic        arg_valid;
  logic [17:0] arg_data;
  logic        arg_ready;
  logic        res_valid;
  logic [63:0] res_data;
  logic        res_ready;
  logic        err;

  int n_cmp;
  int n_err;
  int vec_cnt;
  int snap;

  deserialize dut (
    .clk       (clk),
    .rst       (rst),
    .arg_valid (arg_valid),
    .arg_data  (arg_data),
    .arg_ready (arg_ready),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_ready (res_ready),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count delivered vectors
  always @(posedge clk) begin
    if (!rst && res_valid && res_ready) vec_cnt <= vec_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one beat, wait (bounded) for acceptance, return at edge+1
  task automatic beat(input logic [1:0] idx, input logic [15:0] v);
    bit done;
    done = 0;
    arg_valid = 1'b1;
    arg_data  = {idx, v};
    for (int i = 0; i < 20 && !done; i++) begin
      #1;
      done = arg_ready;
      @(posedge clk);
      #1;
    end
    arg_valid = 1'b0;
    if (!done) chk("beat_timeout", 64'd0, 64'd1);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    vec_cnt = 0;
    rst = 1'b1;
    arg_valid = 1'b0;
    arg_data = '0;
    res_ready = 1'b1;
    #3;
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_data", res_data, 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_arg_ready", 64'(arg_ready), 64'd1);
    #9 rst = 1'b0;
    step();

    // In order
    beat(2'd0, 16'd0);
    beat(2'd1, 16'd1);
    beat(2'd2, 16'd2);
    chk("ord_not_yet", 64'(res_valid), 64'd0);
    beat(2'd3, 16'd3);
    chk("ord_valid", 64'(res_valid), 64'd1);
    chk("ord_data", res_data, 64'h0003_0002_0001_0000);
    chk("ord_err", 64'(err), 64'd0);
    step();
    chk("ord_pulse_end", 64'(res_valid), 64'd0);

    // Reverse order
    beat(2'd3, 16'h30);
    beat(2'd2, 16'h20);
    beat(2'd1, 16'h10);
    chk("rev_not_yet", 64'(res_valid), 64'd0);
    beat(2'd0, 16'h00);
    chk("rev_valid", 64'(res_valid), 64'd1);
    chk("rev_data", res_data, 64'h0030_0020_0010_0000);
    step();
    chk("rev_pulse_end", 64'(res_valid), 64'd0);

    // Backpressure
    res_ready = 1'b0;
    beat(2'd0, 16'd1);
    beat(2'd1, 16'd2);
    beat(2'd2, 16'd3);
    beat(2'd3, 16'd4);
    chk("bp_a_valid", 64'(res_valid), 64'd1);
    chk("bp_a_data", res_data, 64'h0004_0003_0002_0001);
    beat(2'd0, 16'd5);
    beat(2'd1, 16'd6);
    beat(2'd2, 16'd7);
    chk("bp_ready_low", 64'(arg_ready), 64'd0);
    chk("bp_a_hold", res_data, 64'h0004_0003_0002_0001);
    step();
    chk("bp_a_hold_valid", 64'(res_valid), 64'd1);
    chk("bp_a_hold2", res_data, 64'h0004_0003_0002_0001);
    res_ready = 1'b1;
    arg_valid = 1'b1;
    arg_data  = {2'd3, 16'd8};
    #1;
    chk("bp_ready_back", 64'(arg_ready), 64'd1);
    snap = vec_cnt;
    step();
    arg_valid = 1'b0;
    chk("bp_a_taken", 64'(vec_cnt - snap), 64'd1);
    chk("bp_b_valid", 64'(res_valid), 64'd1);
    chk("bp_b_data", res_data, 64'h0008_0007_0006_0005);
    step();
    chk("bp_b_taken", 64'(res_valid), 64'd0);
    chk("bp_err", 64'(err), 64'd0);

    // Duplicate index
    beat(2'd0, 16'd10);
    beat(2'd1, 16'd11);
    chk("dup_err_before", 64'(err), 64'd0);
    beat(2'd1, 16'd99);
    chk("dup_err_set", 64'(err), 64'd1);
    chk("dup_no_vec", 64'(res_valid), 64'd0);
    beat(2'd2, 16'd12);
    chk("dup_still_wait", 64'(res_valid), 64'd0);
    beat(2'd3, 16'd13);
    chk("dup_valid", 64'(res_valid), 64'd1);
    chk("dup_data", res_data, 64'h000d_000c_0063_000a);
    step();
    chk("dup_err_sticky", 64'(err), 64'd1);

    // Reset mid-vector
    beat(2'd0, 16'hAA);
    beat(2'd1, 16'hBB);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_err", 64'(err), 64'd0);
    chk("mid_rst_data", res_data, 64'd0);
    #1 rst = 1'b0;
    step();
    snap = vec_cnt;
    beat(2'd0, 16'd4);
    beat(2'd1, 16'd5);
    beat(2'd2, 16'd6);
    chk("mid_no_early", 64'(res_valid), 64'd0);
    beat(2'd3, 16'd7);
    chk("mid_valid", 64'(res_valid), 64'd1);
    chk("mid_data", res_data, 64'h0007_0006_0005_0004);
    chk("mid_err", 64'(err), 64'd0);
    step();
    step();
    chk("mid_one_vec", 64'(vec_cnt - snap), 64'd1);

    // Streaming: 3 vectors back-to-back
    for (int i = 0; i < 12; i++) begin
      logic [1:0]  k;
      logic [15:0] v;
      k = 2'(i % 4);
      v = 16'(16'h100 * (i / 4) + (i % 4));
      arg_valid = 1'b1;
      arg_data  = {k, v};
      #1;
      chk($sformatf("str_ready_%0d", i), 64'(arg_ready), 64'd1);
      step();
      chk($sformatf("str_valid_%0d", i), 64'(res_valid),
          64'((i % 4) == 3));
      if ((i % 4) == 3) begin
        logic [63:0] e;
        for (int w = 0; w < 4; w++) begin
          e[w*16 +: 16] = 16'(16'h100 * (i / 4) + w);
        end
        chk($sformatf("str_data_%0d", i), res_data, e);
      end
    end
    arg_valid = 1'b0;
    step();
    chk("str_idle", 64'(res_valid), 64'd0);
    chk("str_err", 64'(err), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
